shoe_shuffler: RTL and testbench

- Parametrised successor to the single-deck shuffler.
- Builds an N-deck blackjack shoe and permutes it with an LFSR-driven Fisher-Yates shuffle.
- Deals cards to the game controller over a valid/ready handshake.
- Flags when the cut-card threshold is reached so the controller can request a reshuffle.

---
 rtl/shoe_shuffler.sv | 133 +++++++++++++
 tb/tb_shoe_shuffler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shoe_shuffler.sv
// shoe_shuffler: builds an N-deck blackjack shoe, permutes it with an
// LFSR-driven Fisher-Yates shuffle and deals it over a valid/ready handshake.
//
// state | meaning
// IDLE  | no shoe loaded, waiting for start
// INIT  | writing deck[i] = i % 52, one entry per cycle
// SHUF  | one LFSR step per cycle, swap deck[k] with deck[r] when r <= k
// DEAL  | presenting deck[rd_ptr] until the shoe is empty
module shoe_shuffler #(
  parameter int                NUM_DECKS = 1,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter int                CUT_CARDS = 15,
  localparam int               N         = 52 * NUM_DECKS,
  localparam int               IDX_W     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output logic              card_valid,
  input  logic              card_ready,
  output logic [5:0]        card,
  output logic [IDX_W:0]    cards_left,
  output logic              low_water
);

  typedef enum logic [1:0] {IDLE, INIT, SHUF, DEAL} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [IDX_W-1:0]  k;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  rd_nxt;
  logic [IDX_W-1:0]  mask;
  logic [IDX_W-1:0]  r;
  logic              accept;
  logic [5:0]        face;
  logic [5:0]        deck [N];

  // Next LFSR value, candidate swap index and rejection test for this cycle
  always_comb begin
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    mask = k;
    for (int i = 1; i < IDX_W; i++) begin
      mask = mask | (k >> i);
    end
    r      = lfsr_nxt[IDX_W-1:0] & mask;
    accept = (r <= k);
    rd_nxt = rd_ptr + 1'b1;
  end

  // Cut-card indication only means something while dealing
  assign low_water = (state == DEAL) && (cards_left <= (IDX_W+1)'(CUT_CARDS));

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_W'(1);
      k          <= '0;
      idx        <= '0;
      rd_ptr     <= '0;
      face       <= '0;
      busy       <= 1'b0;
      card_valid <= 1'b0;
      card       <= '0;
      cards_left <= '0;
    end else if (start && (state == IDLE || state == DEAL)) begin
      // a handshake in the same cycle is simply overtaken by the rebuild
      state      <= INIT;
      lfsr       <= (seed == '0) ? LFSR_W'(1) : seed;
      idx        <= '0;
      face       <= '0;
      busy       <= 1'b1;
      card_valid <= 1'b0;
      cards_left <= '0;
    end else begin
      case (state)
        INIT: begin
          idx  <= idx + 1'b1;
          face <= (face == 6'd51) ? 6'd0 : face + 1'b1;
          if (idx == IDX_W'(N - 1)) begin
            state <= SHUF;
            k     <= IDX_W'(N - 1);
          end
        end
        SHUF: begin
          lfsr <= lfsr_nxt;
          if (accept) begin
            k <= k - 1'b1;
            if (k == IDX_W'(1)) begin
              state      <= DEAL;
              rd_ptr     <= '0;
              cards_left <= (IDX_W+1)'(N);
              busy       <= 1'b0;
              card_valid <= 1'b1;
              // deck[0] is rewritten by this final swap when r == 0
              card       <= (r == '0) ? deck[1] : deck[0];
            end
          end
        end
        DEAL: begin
          if (card_valid && card_ready) begin
            rd_ptr     <= rd_nxt;
            cards_left <= cards_left - 1'b1;
            if (cards_left == (IDX_W+1)'(1)) begin
              card_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              card <= deck[rd_nxt];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shoe storage: sequential fill during INIT, pairwise swap during SHUF
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      deck[idx] <= face;
    end else if (state == SHUF && accept) begin
      deck[k] <= deck[r];
      deck[r] <= deck[k];
    end
  end

endmodule

// File: tb/tb_shoe_shuffler.sv
// tb_shoe_shuffler: checks 1-deck and 6-deck shoes against a reference
// Fisher-Yates model, with backpressure, restart and reset corner cases.
module tb_shoe_shuffler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic        card_ready;
  int          sel;

  logic        start1, start6;
  logic        busy1, valid1, lw1;
  logic [5:0]  card1;
  logic [6:0]  left1;
  logic        busy6, valid6, lw6;
  logic [5:0]  card6;
  logic [9:0]  left6;

  logic        o_valid, o_busy, o_lw;
  int          o_card, o_left;

  int n_pass = 0;
  int n_total = 0;
  int lw_first;

  always #5 clk = ~clk;

  assign start1  = start && (sel == 0);
  assign start6  = start && (sel == 1);
  assign o_valid = (sel == 1) ? valid6 : valid1;
  assign o_busy  = (sel == 1) ? busy6 : busy1;
  assign o_lw    = (sel == 1) ? lw6 : lw1;
  assign o_card  = (sel == 1) ? int'(card6) : int'(card1);
  assign o_left  = (sel == 1) ? int'(left6) : int'(left1);

  shoe_shuffler #(.NUM_DECKS(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed), .busy(busy1),
    .card_valid(valid1), .card_ready(card_ready), .card(card1),
    .cards_left(left1), .low_water(lw1)
  );

  shoe_shuffler #(.NUM_DECKS(6)) d6 (
    .clk(clk), .rst(rst), .start(start6), .seed(seed), .busy(busy6),
    .card_valid(valid6), .card_ready(card_ready), .card(card6),
    .cards_left(left6), .low_water(lw6)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference shuffle: plain Fisher-Yates with power-of-two rejection sampling
  task automatic model(input int n, input logic [15:0] sd, output int seq[$], output int shuf);
    int deck[];
    logic [15:0] l;
    int k, r, m, t;
    deck = new[n];
    for (int i = 0; i < n; i++) deck[i] = i % 52;
    l = (sd == 16'h0) ? 16'h1 : sd;
    k = n - 1;
    shuf = 0;
    while (k >= 1) begin
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      shuf++;
      m = 0;
      while (m < k) m = 2 * m + 1;
      r = int'(l) & m;
      if (r <= k) begin
        t = deck[k]; deck[k] = deck[r]; deck[r] = t;
        k--;
      end
    end
    seq = {};
    for (int i = 0; i < n; i++) seq.push_back(deck[i]);
  endtask

  function automatic int seq_diff(input int a[$], input int b[$]);
    int d = 0;
    if (a.size() != b.size()) return 9999;
    for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  function automatic int hist_bad(input int q[$], input int per);
    int h[52];
    int bad = 0;
    for (int i = 0; i < 52; i++) h[i] = 0;
    foreach (q[i]) begin
      if (q[i] >= 0 && q[i] < 52) h[q[i]]++;
      else bad++;
    end
    for (int i = 0; i < 52; i++) if (h[i] != per) bad++;
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] sd);
    start = 1'b1;
    seed  = sd;
    tick();
    start = 1'b0;
  endtask

  // Waits for the shoe, then drains up to limit cards while checking the protocol
  task automatic collect(input bit bp, input int limit, input int lat0,
                         output int got[$], output int lat);
    int n, bad_busy, bad_stab, bad_cl, bad_lw, guard, prev_card;
    bit prev_stall;
    n = (sel == 1) ? 312 : 52;
    got = {};
    lat = lat0;
    bad_busy = 0; bad_stab = 0; bad_cl = 0; bad_lw = 0;
    while (!o_valid && lat < 4000) begin
      if (!o_busy) bad_busy++;
      tick();
      lat++;
    end
    check("first_card_seen", o_valid, 1);
    lw_first = -1;
    prev_stall = 1'b0;
    prev_card = 0;
    guard = 0;
    while (o_valid && got.size() < limit && guard < 8000) begin
      guard++;
      if (o_busy) bad_busy++;
      if (prev_stall && o_card != prev_card) bad_stab++;
      if (o_left != n - got.size()) bad_cl++;
      if (o_lw !== ((n - got.size()) <= 15)) bad_lw++;
      if (o_lw && lw_first < 0) lw_first = o_left;
      prev_card  = o_card;
      card_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = !card_ready;
      if (card_ready) got.push_back(o_card);
      tick();
    end
    card_ready = 1'b1;
    check("busy_profile", bad_busy, 0);
    check("card_stable_stall", bad_stab, 0);
    check("cards_left_track", bad_cl, 0);
    check("low_water_track", bad_lw, 0);
  endtask

  task automatic run_full(input logic [15:0] sd, input bit bp, input int exp_cards,
                          output int got[$]);
    int exp_seq[$];
    int shuf, lat, n;
    n = (sel == 1) ? 312 : 52;
    model(n, sd, exp_seq, shuf);
    pulse(sd);
    collect(bp, 100000, 1, got, lat);
    check("latency", lat, 1 + n + shuf);
    check("card_count", got.size(), exp_cards);
    check("order_vs_model", seq_diff(got, exp_seq), 0);
    check("value_histogram", hist_bad(got, n / 52), 0);
    check("end_valid_low", o_valid, 0);
    check("end_cards_left", o_left, 0);
  endtask

  typedef struct {
    logic [15:0] seed;
    bit          bp;
    int          exp_cards;
  } vec_t;

  vec_t vecs[7];
  int   runs[7][$];

  initial begin
    int got[$];
    int exp_seq[$];
    int shuf, lat, bad;

    vecs[0] = '{16'hACE1, 1'b0, 52};
    vecs[1] = '{16'h0000, 1'b0, 52};
    vecs[2] = '{16'h0001, 1'b0, 52};
    vecs[3] = '{16'hACE1, 1'b1, 52};
    for (int i = 4; i < 7; i++) vecs[i] = '{16'($urandom()), 1'b1, 52};

    rst = 1'b1; start = 1'b0; seed = 16'h0; card_ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_busy1", busy1, 0);
    check("rst_valid1", valid1, 0);
    check("rst_card1", card1, 0);
    check("rst_left1", left1, 0);
    check("rst_lw1", lw1, 0);
    check("rst_busy6", busy6, 0);
    check("rst_valid6", valid6, 0);
    check("rst_left6", left6, 0);
    rst = 1'b0;
    card_ready = 1'b1;
    tick();
    check("idle_no_valid", valid1, 0);

    for (int i = 0; i < 7; i++) begin
      run_full(vecs[i].seed, vecs[i].bp, vecs[i].exp_cards, got);
      runs[i] = got;
    end
    check("seed0_eq_seed1", seq_diff(runs[1], runs[2]), 0);
    check("bp_eq_ready_run", seq_diff(runs[3], runs[0]), 0);
    check("seeds_differ", seq_diff(runs[0], runs[2]) != 0, 1);

    // six-deck shoe
    sel = 1;
    run_full(16'h1234, 1'b0, 312, got);
    check("lw_first_left", lw_first, 15);
    sel = 0;

    // restart after 20 cards, start coinciding with a handshake
    model(52, 16'hACE1, exp_seq, shuf);
    pulse(16'hACE1);
    collect(1'b0, 20, 1, got, lat);
    check("partial_20_order", seq_diff(got, exp_seq[0:19]), 0);
    check("valid_before_restart", valid1, 1);
    start = 1'b1; seed = 16'h5A5A;
    tick();
    start = 1'b0;
    check("restart_valid_low", valid1, 0);
    check("restart_left_zero", left1, 0);
    check("restart_busy", busy1, 1);
    model(52, 16'h5A5A, exp_seq, shuf);
    collect(1'b0, 100000, 1, got, lat);
    check("restart_latency", lat, 1 + 52 + shuf);
    check("restart_order", seq_diff(got, exp_seq), 0);

    // start during SHUF must be ignored
    model(52, 16'h7777, exp_seq, shuf);
    pulse(16'h7777);
    repeat (59) tick();
    check("busy_in_shuf", busy1, 1);
    start = 1'b1; seed = 16'h1111;
    tick();
    start = 1'b0;
    collect(1'b0, 100000, 61, got, lat);
    check("shuf_start_latency", lat, 1 + 52 + shuf);
    check("shuf_start_order", seq_diff(got, exp_seq), 0);

    // asynchronous reset mid-SHUF
    pulse(16'h2468);
    repeat (70) tick();
    check("pre_rst_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy1, 0);
    check("async_rst_valid", valid1, 0);
    check("async_rst_left", left1, 0);
    check("async_rst_card", card1, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid1 !== 1'b0) bad++;
    end
    check("no_valid_after_rst", bad, 0);
    run_full(16'h2468, 1'b1, 52, got);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
